uart_rx: RTL and testbench

Serial receiver for the FPGA UART link. It deserializes 8N1 frames (1 start bit, 8 data bits LSB-first, no parity, 1 stop bit) arriving on an asynchronous pin. It sits beside the UART transmitter under the same top, sharing its clock and `CLKS_PER_BIT` setting. Received bytes are presented to fabric logic as a one-cycle valid strobe.

---
 rtl/uart_rx.sv | 167 ++++++++++++++++
 tb/tb_uart_rx.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a 2-flop input synchronizer and mid-bit sampling.
// Define UART_RX_MAJORITY_EN to take each sample as a 2-of-3 vote over the last three synced cycles.
module uart_rx #(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_rx_serial,
    output logic       o_rx_dv,
    output logic [7:0] o_rx_byte,
    output logic       o_rx_active,
    output logic       o_frame_err
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_BIT  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'((CLKS_PER_BIT - 1) / 2);

    typedef enum logic [2:0] {
        IDLE,
        START_BIT,
        DATA_BITS,
        STOP_BIT,
        BREAK_WAIT
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      byte_q, byte_d;
    logic            dv_q, dv_d;
    logic            ferr_q, ferr_d;
    logic            active_q, active_d;
    logic            sync1_q, sync2_q;
    logic            rxs;
    logic            sample;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= i_rx_serial;
            sync2_q <= sync1_q;
        end
    end

    assign rxs = sync2_q;

`ifdef UART_RX_MAJORITY_EN
    // Two registered taps plus the live synced bit form the 3-cycle window ending at the sample point.
    logic [1:0] hist_q;
    logic [2:0] hist;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hist_q <= '1;
        end else begin
            hist_q <= {hist_q[0], rxs};
        end
    end

    assign hist   = {hist_q, rxs};
    assign sample = (hist[2] & hist[1]) | (hist[2] & hist[0]) | (hist[1] & hist[0]);
`else
    assign sample = rxs;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            byte_q   <= '0;
            dv_q     <= 1'b0;
            ferr_q   <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            byte_q   <= byte_d;
            dv_q     <= dv_d;
            ferr_q   <= ferr_d;
            active_q <= active_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        byte_d   = byte_q;
        dv_d     = 1'b0;
        ferr_d   = 1'b0;
        active_d = active_q;

        unique case (state_q)
            IDLE: begin
                active_d = 1'b0;
                if (!rxs) begin
                    cnt_d    = CNT_HALF;
                    active_d = 1'b1;
                    state_d  = START_BIT;
                end
            end
            START_BIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (!sample) begin
                    cnt_d   = CNT_BIT;
                    idx_d   = '0;
                    state_d = DATA_BITS;
                end else begin
                    active_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            DATA_BITS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    shift_d[idx_q] = sample;
                    cnt_d          = CNT_BIT;
                    if (idx_q == 3'd7) begin
                        state_d = STOP_BIT;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            STOP_BIT: begin
                // Leaving at mid-stop-bit gives IDLE half a bit of margin before a back-to-back start edge.
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (sample) begin
                    byte_d   = shift_q;
                    dv_d     = 1'b1;
                    active_d = 1'b0;
                    state_d  = IDLE;
                end else begin
                    ferr_d  = 1'b1;
                    state_d = BREAK_WAIT;
                end
            end
            BREAK_WAIT: begin
                if (rxs) begin
                    active_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: begin
                active_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    assign o_rx_dv     = dv_q;
    assign o_rx_byte   = byte_q;
    assign o_rx_active = active_q;
    assign o_frame_err = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: table-driven and randomized checks of uart_rx against a waveform-sampling reference model.
// Honours UART_RX_MAJORITY_EN when choosing the expected result of the sample-point glitch vector.
`timescale 1ns/1ps
module tb_uart_rx;
    localparam int CPB   = 217;
    localparam int H     = (CPB - 1) / 2;
    localparam int FRAME = 10 * CPB;
    localparam int LAT   = 2065;          // pin falling edge to strobe cycle
    localparam int SOFF  = 1 + H;         // pin-relative offset of the start-bit sample

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       rx    = 1'b1;
    logic       dv, act, ferr;
    logic [7:0] rbyte;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_rx_serial (rx),
        .o_rx_dv     (dv),
        .o_rx_byte   (rbyte),
        .o_rx_active (act),
        .o_frame_err (ferr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         is_err;
        logic [7:0] b;
        int         c;
    } ev_t;

    ev_t act_q[$];
    ev_t exp_q[$];
    int  act_rises   = 0;
    int  dv_with_act = 0;
    int  dv_and_ferr = 0;
    logic prev_act   = 1'b0;

    always @(negedge clk) begin
        if (dv || ferr) begin
            ev_t e;
            e.is_err = ferr;
            e.b      = rbyte;
            e.c      = cyc;
            act_q.push_back(e);
        end
        if (dv && act) dv_with_act++;
        if (dv && ferr) dv_and_ferr++;
        if (act && !prev_act) act_rises++;
        prev_act = act;
    end

    int         errors = 0;
    int         checks = 0;
    logic       wave [FRAME];
    logic [7:0] model_byte = 8'h00;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference: sample the transmitted pin waveform at the nominal mid-bit points.
    function automatic bit model_sample(input int off);
`ifdef UART_RX_MAJORITY_EN
        int ones;
        ones = int'(wave[off-2]) + int'(wave[off-1]) + int'(wave[off]);
        return ones >= 2;
`else
        return wave[off];
`endif
    endfunction

    task automatic predict(input int fall);
        ev_t        e;
        logic [7:0] d;
        if (model_sample(SOFF)) return;
        for (int k = 0; k < 8; k++) d[k] = model_sample(SOFF + (k + 1) * CPB);
        e.c = fall + LAT;
        if (model_sample(SOFF + 9 * CPB)) begin
            model_byte = d;
            e.is_err   = 1'b0;
        end else begin
            e.is_err   = 1'b1;
        end
        e.b = model_byte;
        exp_q.push_back(e);
    endtask

    task automatic build(input logic [7:0] d, input bit stop_ok, input int glitch);
        for (int c = 0; c < FRAME; c++) begin
            int   bi;
            logic lv;
            bi = c / CPB;
            if (bi == 0)      lv = 1'b0;
            else if (bi <= 8) lv = d[bi-1];
            else              lv = stop_ok;
            if (c == glitch) lv = ~lv;
            wave[c] = lv;
        end
    endtask

    task automatic send(input logic [7:0] d, input bit stop_ok, input int glitch,
                        input int idle_after, input bit end_level);
        int fall;
        build(d, stop_ok, glitch);
        fall = cyc;
        for (int c = 0; c < FRAME; c++) begin
            rx = wave[c];
            tick(1);
        end
        rx = end_level;
        predict(fall);
        tick(idle_after);
    endtask

    task automatic check_events(input string name);
        ev_t e, a;
        checks++;
        if (act_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s: event count got %0d expected %0d", name, act_q.size(), exp_q.size());
            act_q.delete();
            exp_q.delete();
            return;
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = act_q.pop_front();
            checks++;
            if (a.is_err != e.is_err || a.b !== e.b || a.c < e.c - 1 || a.c > e.c + 1) begin
                errors++;
                $display("FAIL %s: got err=%0d byte=%02h cyc=%0d expected err=%0d byte=%02h cyc=%0d",
                         name, a.is_err, a.b, a.c, e.is_err, e.b, e.c);
            end
        end
    endtask

    typedef struct {
        logic [7:0] d;
        bit         stop_ok;
        int         glitch;
        bit         exp_err;
        logic [7:0] exp_byte;
    } vec_t;

    initial begin
        vec_t vecs[6];
        int   r0;

        vecs[0] = '{8'hA5, 1'b1, -1,  1'b0, 8'hA5};
        vecs[1] = '{8'h3C, 1'b0, -1,  1'b1, 8'hA5};
        vecs[2] = '{8'h5A, 1'b1, -1,  1'b0, 8'h5A};
`ifdef UART_RX_MAJORITY_EN
        vecs[3] = '{8'h00, 1'b1, 760, 1'b0, 8'h00};
`else
        vecs[3] = '{8'h00, 1'b1, 760, 1'b0, 8'h04};
`endif
        vecs[4] = '{8'hFF, 1'b1, -1,  1'b0, 8'hFF};
        vecs[5] = '{8'h81, 1'b1, 300, 1'b0, 8'h81};

        #2 rst_n = 1'b0;
        tick(3);
        chk("reset_dv",     int'(dv),    0);
        chk("reset_byte",   int'(rbyte), 0);
        chk("reset_active", int'(act),   0);
        chk("reset_ferr",   int'(ferr),  0);
        rst_n = 1'b1;
        tick(5);

        for (int i = 0; i < 6; i++) begin
            send(vecs[i].d, vecs[i].stop_ok, vecs[i].glitch, 100, 1'b1);
            chk($sformatf("vec%0d_events", i), act_q.size(), 1);
            if (act_q.size() == 1) chk($sformatf("vec%0d_kind", i), int'(act_q[0].is_err), int'(vecs[i].exp_err));
            chk($sformatf("vec%0d_byte", i), int'(rbyte), int'(vecs[i].exp_byte));
            check_events($sformatf("vec%0d_model", i));
        end

        // False start: 50-cycle low pulse on an idle line.
        r0 = act_rises;
        rx = 1'b0;
        tick(50);
        rx = 1'b1;
        tick(300);
        chk("false_start_active_pulse", act_rises - r0, 1);
        chk("false_start_active_end",   int'(act), 0);
        check_events("false_start_no_strobe");

        // Framing error followed by a 1000-cycle break.
        send(8'h3C, 1'b0, -1, 1000, 1'b0);
        chk("break_active_held", int'(act), 1);
        chk("break_byte_kept",   int'(rbyte), 8'h81);
        rx = 1'b1;
        tick(10);
        chk("break_release_active", int'(act), 0);
        check_events("break_single_ferr");
        send(8'h5A, 1'b1, -1, 100, 1'b1);
        chk("after_break_byte", int'(rbyte), 8'h5A);
        check_events("after_break");

        // Back-to-back frames with zero idle.
        send(8'h00, 1'b1, -1, 0,   1'b1);
        send(8'hFF, 1'b1, -1, 100, 1'b1);
        chk("b2b_events", act_q.size(), 2);
        if (act_q.size() == 2) chk("b2b_gap", act_q[1].c - act_q[0].c, FRAME);
        check_events("b2b");

        // Reset asserted during data bit 4.
        build(8'hC3, 1'b1, -1);
        for (int c = 0; c < 5 * CPB + 100; c++) begin
            rx = wave[c];
            tick(1);
        end
        chk("midframe_active", int'(act), 1);
        rst_n = 1'b0;
        rx    = 1'b1;
        #1;
        chk("midreset_dv",     int'(dv),    0);
        chk("midreset_byte",   int'(rbyte), 0);
        chk("midreset_active", int'(act),   0);
        chk("midreset_ferr",   int'(ferr),  0);
        tick(5);
        rst_n      = 1'b1;
        model_byte = 8'h00;
        tick(300);
        check_events("midreset_no_strobe");
        send(8'h81, 1'b1, -1, 100, 1'b1);
        chk("after_reset_byte", int'(rbyte), 8'h81);
        check_events("after_reset");

        // Randomized frames: data, stop validity and glitches near sample points.
        for (int i = 0; i < 10; i++) begin
            logic [7:0] d;
            bit         ok;
            int         g, idle;
            d  = 8'($urandom);
            ok = ($urandom_range(0, 3) != 0);
            g  = -1;
            if ($urandom_range(0, 1) == 1)
                g = SOFF + (int'($urandom_range(0, 7)) + 1) * CPB + int'($urandom_range(0, 4)) - 2;
            idle = ok ? int'($urandom_range(0, 100)) : int'($urandom_range(20, 100));
            send(d, ok, g, idle, 1'b1);
            tick(5);
            check_events($sformatf("rand%0d", i));
            chk($sformatf("rand%0d_byte", i), int'(rbyte), int'(model_byte));
        end

        chk("active_low_with_dv",  dv_with_act, 0);
        chk("dv_ferr_exclusive",   dv_and_ferr, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
